clock_divider: RTL and testbench

- Programmable integer clock divider.
- Divides reference clock `clk_ref` by runtime ratio `div_ratio`; supports odd and even ratios.
- Used wherever a slower derived clock is needed, e.g. UART baud/TX/RX clocks.
- Passes `clk_ref` through unchanged when disabled or when ratio is 0 or 1.

---
 rtl/clock_divider.sv | 61 ++++++
 tb/tb_clock_divider.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/clock_divider.sv
// Programmable integer clock divider: divides clk_ref by div_ratio (odd or even ratios),
// passing clk_ref straight through when disabled or when the ratio is 0 or 1.
module clock_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk_ref,
  input  logic             rst,
  input  logic             i_clk_en,
  input  logic [WIDTH-1:0] div_ratio,
  output logic             o_div_clk
);

  logic             div_active_s;
  logic [WIDTH-1:0] half_s;
  logic [WIDTH:0]   phase_len_s;
  logic [WIDTH:0]   cnt_inc_s;
  logic             toggle_s;
  logic [WIDTH-1:0] cnt_r;
  logic             div_clk_q;

  // Phase length from the live ratio; an odd ratio stretches the low phase by one cycle
  always_comb begin
    div_active_s = i_clk_en && (div_ratio > {{(WIDTH-1){1'b0}}, 1'b1});
    half_s       = div_ratio >> 1;
    if (div_clk_q) begin
      phase_len_s = {1'b0, half_s};
    end else begin
      phase_len_s = {1'b0, half_s} + {{WIDTH{1'b0}}, div_ratio[0]};
    end
    cnt_inc_s = {1'b0, cnt_r} + {{WIDTH{1'b0}}, 1'b1};
    // >= rather than == so a ratio shrunk mid-phase toggles at once instead of wrapping
    toggle_s  = (cnt_inc_s >= phase_len_s);
  end

  // Phase counter and divided clock register; held at zero whenever not dividing
  always_ff @(posedge clk_ref or negedge rst) begin
    if (!rst) begin
      cnt_r     <= {WIDTH{1'b0}};
      div_clk_q <= 1'b0;
    end else if (!div_active_s) begin
      cnt_r     <= {WIDTH{1'b0}};
      div_clk_q <= 1'b0;
    end else if (toggle_s) begin
      cnt_r     <= {WIDTH{1'b0}};
      div_clk_q <= ~div_clk_q;
    end else begin
      cnt_r     <= cnt_inc_s[WIDTH-1:0];
      div_clk_q <= div_clk_q;
    end
  end

  // Output select: registered divided clock, or raw reference in bypass
  always_comb begin
    if (div_active_s) begin
      o_div_clk = div_clk_q;
    end else begin
      o_div_clk = clk_ref;
    end
  end

endmodule

// File: tb/tb_clock_divider.sv
// Directed bench for clock_divider: table of ratios with expected high/low phase lengths
// (in clk_ref cycles) plus hand sequences for reset, ratio sweep and disable/re-enable.
module tb_clock_divider;

  logic       clk_ref;
  logic       rst;
  logic       i_clk_en;
  logic [7:0] div_ratio;
  logic       o_div_clk;

  int n_pass;
  int n_total;

  typedef struct {
    logic       en;
    logic [7:0] ratio;
    int         hi;   // expected high-phase cycles, 0 means bypass expected
    int         lo;   // expected low-phase cycles
  } vec_t;

  vec_t vecs[10];

  clock_divider #(.WIDTH(8)) dut (
    .clk_ref   (clk_ref),
    .rst       (rst),
    .i_clk_en  (i_clk_en),
    .div_ratio (div_ratio),
    .o_div_clk (o_div_clk)
  );

  initial clk_ref = 1'b0;
  always #5 clk_ref = ~clk_ref;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Measures one full high and following low phase, sampling 1 time unit after each posedge.
  task automatic measure(output int hi, output int lo);
    int   n;
    logic prev;
    hi = -1;
    lo = -1;
    n  = 0;
    do begin
      prev = o_div_clk;
      @(posedge clk_ref); #1;
      n++;
    end while (!(prev == 1'b0 && o_div_clk == 1'b1) && n < 600);
    if (n >= 600) return;
    hi = 0;
    n  = 0;
    while (o_div_clk == 1'b1 && n < 600) begin
      hi++;
      @(posedge clk_ref); #1;
      n++;
    end
    if (n >= 600) begin
      hi = -1;
      return;
    end
    lo = 0;
    n  = 0;
    while (o_div_clk == 1'b0 && n < 600) begin
      lo++;
      @(posedge clk_ref); #1;
      n++;
    end
    if (n >= 600) lo = -1;
  endtask

  task automatic check_bypass(input string name);
    int errs;
    errs = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk_ref); #1;
      if (o_div_clk !== 1'b1) errs++;
      @(negedge clk_ref); #1;
      if (o_div_clk !== 1'b0) errs++;
    end
    check(name, errs, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int         hi;
    int         lo;
    int         errs;
    int         exp_hi;
    int         exp_lo;
    time        t0;
    logic [7:0] pattern;

    n_pass  = 0;
    n_total = 0;

    vecs[0] = '{1'b1, 8'd2,   1,   1};
    vecs[1] = '{1'b1, 8'd6,   3,   3};
    vecs[2] = '{1'b1, 8'd3,   1,   2};
    vecs[3] = '{1'b1, 8'd5,   2,   3};
    vecs[4] = '{1'b1, 8'd7,   3,   4};
    vecs[5] = '{1'b1, 8'd4,   2,   2};
    vecs[6] = '{1'b1, 8'd255, 127, 128};
    vecs[7] = '{1'b1, 8'd0,   0,   0};
    vecs[8] = '{1'b1, 8'd1,   0,   0};
    vecs[9] = '{1'b0, 8'd8,   0,   0};

    // Reset held with divider enabled at N=4: output must stay low on both clock levels
    rst       = 1'b0;
    i_clk_en  = 1'b1;
    div_ratio = 8'd4;
    errs      = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_ref); #1;
      if (o_div_clk !== 1'b0) errs++;
      @(negedge clk_ref); #1;
      if (o_div_clk !== 1'b0) errs++;
    end
    check("reset_low", errs, 0);

    // Release just after an edge: low for 2 cycles, high for 2, repeating
    @(posedge clk_ref); #1;
    rst     = 1'b1;
    pattern = 8'b0110_0110;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk_ref); #1;
      check($sformatf("post_reset_edge%0d", i + 1), int'(o_div_clk), int'(pattern[7-i]));
    end

    // Table of ratios: discard one period to settle, then check three periods
    for (int v = 0; v < 10; v++) begin
      i_clk_en  = vecs[v].en;
      div_ratio = vecs[v].ratio;
      if (vecs[v].hi == 0) begin
        check_bypass($sformatf("bypass_en%0d_n%0d", vecs[v].en, vecs[v].ratio));
      end else begin
        measure(hi, lo);
        for (int p = 0; p < 3; p++) begin
          measure(hi, lo);
          check($sformatf("n%0d_hi_p%0d", vecs[v].ratio, p), hi, vecs[v].hi);
          check($sformatf("n%0d_lo_p%0d", vecs[v].ratio, p), lo, vecs[v].lo);
        end
      end
    end

    // Ratio sweep 0..7, one step per 200 time units, checked within one output period
    i_clk_en = 1'b1;
    for (int n = 0; n < 8; n++) begin
      @(posedge clk_ref); #1;
      t0        = $time;
      div_ratio = 8'(n);
      if (n < 2) begin
        check_bypass($sformatf("sweep_bypass_n%0d", n));
      end else begin
        exp_hi = n / 2;
        exp_lo = n - (n / 2);
        measure(hi, lo);
        check($sformatf("sweep_n%0d_hi", n), hi, exp_hi);
        check($sformatf("sweep_n%0d_lo", n), lo, exp_lo);
      end
      while ($time < t0 + 200) @(posedge clk_ref);
      #1;
    end

    // Disable in the middle of a high phase at N=4, then re-enable
    div_ratio = 8'd4;
    measure(hi, lo);
    measure(hi, lo);
    check("pre_disable_high", int'(o_div_clk), 1);
    i_clk_en = 1'b0;
    @(negedge clk_ref); #1;
    check("disable_follows_clk_low", int'(o_div_clk), 0);
    check_bypass("disabled_bypass");
    @(posedge clk_ref); #1;
    i_clk_en = 1'b1;
    #1;
    check("reenable_immediate_low", int'(o_div_clk), 0);
    pattern = 8'b0110_0110;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk_ref); #1;
      check($sformatf("reenable_edge%0d", i + 1), int'(o_div_clk), int'(pattern[7-i]));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
